// File: rtl/ahb_copy_master.sv
// ---------------------------------------------------------------------------
// ahb_copy_master
//
// AHB-Lite initiator that copies a block of 32-bit words from a source to a
// destination address using alternating single NONSEQ reads and writes. The
// copy stops when the word count reaches zero or a slave answers ERROR.
//
// Optional feature: define AHB_COPY_FILL_EN to add the `fill` / `fill_data`
// inputs. A start with fill=1 skips the reads and writes the latched
// fill_data pattern to every destination word.
//
// Ports
//   HCLK, HRESETn         bus clock, async active-low reset
//   start                 one-cycle request, sampled only when idle
//   src_addr, dst_addr    byte addresses; bits [1:0] ignored
//   len_words             number of words to copy (0 = no bus traffic)
//   fill, fill_data       (AHB_COPY_FILL_EN only) pattern-fill request
//   busy                  high while a request is in progress
//   done                  one-cycle completion pulse
//   error                 abort flag, valid with done, held until next start
//   HADDR..HWDATA         AHB-Lite master outputs (HSIZE fixed to word)
//   HRDATA, HREADY, HRESP AHB-Lite master inputs
// ---------------------------------------------------------------------------
module ahb_copy_master #(
  parameter int LENWIDTH = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LENWIDTH-1:0] len_words,
`ifdef AHB_COPY_FILL_EN
  input  logic                fill,
  input  logic [31:0]         fill_data,
`endif
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [31:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [31:0]         HWDATA,
  input  logic [31:0]         HRDATA,
  input  logic                HREADY,
  input  logic                HRESP
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    FINISH
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [LENWIDTH-1:0] ONE_WORD = {{(LENWIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [31:0]         src_q, dst_q, data_q;
  logic [LENWIDTH-1:0] cnt_q;
  logic                fill_q, error_q;

  // Fill request as seen by the core; tied off in the copy-only build.
  logic        start_fill;
  logic [31:0] start_fill_data;
`ifdef AHB_COPY_FILL_EN
  assign start_fill      = fill;
  assign start_fill_data = fill_data;
`else
  assign start_fill      = 1'b0;
  assign start_fill_data = 32'h0;
`endif

  // Byte-lane bits of the addresses are discarded; word alignment is forced.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  logic accept, rd_ok, wr_ok, bus_err, last_word;
  assign accept    = (state_q == IDLE) && start;
  assign rd_ok     = (state_q == RD_DATA) && HREADY && !HRESP;
  assign wr_ok     = (state_q == WR_DATA) && HREADY && !HRESP;
  // HRESP is honoured in the first cycle of the two-cycle ERROR response,
  // so the bus is already back at IDLE in the following cycle.
  assign bus_err   = ((state_q == RD_DATA) || (state_q == WR_DATA)) && HRESP;
  assign last_word = (cnt_q == ONE_WORD);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words == '0) state_d = FINISH;
          else if (start_fill) state_d = WR_ADDR;
          else                 state_d = RD_ADDR;
        end
      end
      RD_ADDR: if (HREADY) state_d = RD_DATA;
      RD_DATA: begin
        if (HRESP)       state_d = FINISH;
        else if (HREADY) state_d = WR_ADDR;
      end
      WR_ADDR: if (HREADY) state_d = WR_DATA;
      WR_DATA: begin
        if (HRESP)          state_d = FINISH;
        else if (HREADY) begin
          if (last_word)    state_d = FINISH;
          else if (fill_q)  state_d = WR_ADDR;
          else              state_d = RD_ADDR;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      // NOTE: the data register is reset too because it drives HWDATA,
      // which must come out of reset at zero.
      data_q  <= 32'h0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        error_q <= 1'b0;
        src_q   <= {src_addr[31:2], 2'b00};
        dst_q   <= {dst_addr[31:2], 2'b00};
        cnt_q   <= len_words;
        fill_q  <= start_fill;
        if (start_fill) data_q <= start_fill_data;
      end
      if (rd_ok) data_q <= HRDATA;
      if (wr_ok) begin
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        cnt_q <= cnt_q - ONE_WORD;
      end
      if (bus_err) error_q <= 1'b1;
    end
  end

  // Address-phase outputs decode straight from the state register, so they
  // hold through wait states and collapse to reset values with the FSM.
  assign HTRANS = ((state_q == RD_ADDR) || (state_q == WR_ADDR)) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HWRITE = (state_q == WR_ADDR);
  assign HADDR  = (state_q == WR_ADDR) ? dst_q : src_q;
  assign HSIZE  = 3'b010;
  assign HWDATA = data_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FINISH);
  assign error  = error_q;

endmodule

// File: tb/tb_ahb_copy_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_copy_master
//
// Bench for ahb_copy_master. A word-addressed memory slave with configurable
// wait states and ERROR injection answers the bus. For every request the
// stimulus side computes the expected transfer list and completion cycle from
// a word-level copy model and queues them; the slave/monitor process pops and
// compares on every accepted transfer, every write data beat and every done.
// ---------------------------------------------------------------------------
module tb_ahb_copy_master;

  localparam int LW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_addr = '0, dst_addr = '0;
  logic [LW-1:0] len_words = '0;
`ifdef AHB_COPY_FILL_EN
  logic          fill = 1'b0;
  logic [31:0]   fill_data = '0;
`endif
  logic          busy, done, error;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HRDATA = '0;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;

  ahb_copy_master #(.LENWIDTH(LW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
`ifdef AHB_COPY_FILL_EN
    .fill(fill), .fill_data(fill_data),
`endif
    .busy(busy), .done(done), .error(error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit wr; bit [31:0] addr; bit [31:0] data; } xfer_t;
  typedef struct { int unsigned cyc; bit err; } done_t;
  xfer_t exp_q[$];
  done_t done_q[$];

  // Slave memory (changed by the bus) and model memory (changed by the model).
  bit [31:0] mem [bit [31:0]];
  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] pend_mem [bit [31:0]];

  function automatic bit [31:0] init_word(input bit [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Slave configuration, written by stimulus only while the DUT is idle.
  int ws = 0;
  int err_at = -1;
  int xfer_idx = 0;
  int done_cnt = 0;

  // Slave protocol state.
  bit        dp_active, dp_write, dp_err, err2, aw_active, aw_write, wd_seen;
  bit [31:0] dp_addr, dp_data, aw_addr, wd_first;
  int        wait_left, aw_left;

  // Word-level model: the copy is a list of reads and writes in order; the
  // transfer numbered err_at is answered with ERROR and ends the list.
  // Returns the number of completed transfers and whether an error ended it.
  task automatic plan(input bit [31:0] src, input bit [31:0] dst, input int len,
                      input bit fl, input bit [31:0] fd, input int eat,
                      output int ntr, output bit e);
    bit [31:0] a, w, d;
    pend_mem = ref_mem;
    ntr = 0;
    e = 1'b0;
    d = '0;
    for (int i = 0; i < len && !e; i++) begin
      a = src + 32'(4 * i);
      w = dst + 32'(4 * i);
      if (fl) d = fd;
      else begin
        exp_q.push_back('{1'b0, a, 32'h0});
        if (ntr == eat) e = 1'b1;
        else begin
          d = pend_mem.exists(a) ? pend_mem[a] : init_word(a);
          ntr++;
        end
      end
      if (!e) begin
        exp_q.push_back('{1'b1, w, d});
        if (ntr == eat) e = 1'b1;
        else begin
          pend_mem[w] = d;
          ntr++;
        end
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) @(negedge HCLK);
    check("idle_before_start", busy, 1'b0);
  endtask

  task automatic run_copy(input bit [31:0] src, input bit [31:0] dst, input int len,
                          input int w, input int eat, input bit fl,
                          input bit [31:0] fd, input bit poke);
    int ntr, d0;
    bit e;
    wait_idle();
    @(negedge HCLK);
    ws = w;
    err_at = eat;
    xfer_idx = 0;
    plan({src[31:2], 2'b00}, {dst[31:2], 2'b00}, len, fl, fd, eat, ntr, e);
    // Each transfer costs an address and a data phase, each 1+w cycles; an
    // ERROR ends the data phase one cycle after its waits, like a normal beat.
    done_q.push_back('{cyc + 32'(1 + (ntr + int'(e)) * (2 + 2 * w)), e});
    src_addr = src;
    dst_addr = dst;
    len_words = LW'(len);
`ifdef AHB_COPY_FILL_EN
    fill = fl;
    fill_data = fd;
`endif
    start = 1'b1;
    d0 = done_cnt;
    @(negedge HCLK);
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len_words = LW'($urandom);
    if (poke && len > 0) begin
      @(negedge HCLK);
      check("busy_during_copy", busy, 1'b1);
      start = 1'b1;
      len_words = LW'(7);
      @(negedge HCLK);
      start = 1'b0;
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge HCLK);
    check("done_seen", done_cnt - d0, 1);
    if (done_cnt == d0) begin
      exp_q.delete();
      done_q.delete();
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
    end else begin
      @(negedge HCLK);
      check("busy_after_done", busy, 1'b0);
      check("error_held", error, e);
      ref_mem = pend_mem;
    end
  endtask

  // Slave + monitor: all bus responses and all comparisons against queued
  // expectations happen here, on the falling edge.
  initial begin
    xfer_t x;
    done_t dx;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_active = 0; err2 = 0; aw_active = 0; wait_left = 0; aw_left = 0;
        HREADY = 1'b1;
        HRESP = 1'b0;
        continue;
      end
      if (done) begin
        check("done_expected", done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) begin
          dx = done_q.pop_front();
          check("done_cycle", cyc, dx.cyc);
          check("error_at_done", error, dx.err);
        end
        check("htrans_at_done", HTRANS, 2'b00);
        check("pending_xfers", exp_q.size(), 0);
        exp_q.delete();
        done_cnt++;
      end
      HRDATA = $urandom;
      if (err2) begin
        HREADY = 1'b1;
        HRESP = 1'b1;
        err2 = 0;
      end else if (dp_active) begin
        HRESP = 1'b0;
        if (dp_write && !wd_seen) begin
          wd_first = HWDATA;
          wd_seen = 1;
        end else if (dp_write) check("hwdata_hold", HWDATA, wd_first);
        if (wait_left > 0) begin
          HREADY = 1'b0;
          wait_left--;
        end else if (dp_err) begin
          HREADY = 1'b0;
          HRESP = 1'b1;
          err2 = 1;
          dp_active = 0;
        end else begin
          HREADY = 1'b1;
          dp_active = 0;
          if (dp_write) begin
            check("hwdata", HWDATA, dp_data);
            mem[dp_addr] = HWDATA;
          end else HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : init_word(dp_addr);
        end
      end else if (HTRANS == 2'b10) begin
        HRESP = 1'b0;
        if (!aw_active) begin
          aw_active = 1;
          aw_left = ws;
          aw_addr = HADDR;
          aw_write = HWRITE;
        end else begin
          check("haddr_hold", HADDR, aw_addr);
          check("hwrite_hold", HWRITE, aw_write);
        end
        if (aw_left > 0) begin
          HREADY = 1'b0;
          aw_left--;
        end else begin
          HREADY = 1'b1;
          aw_active = 0;
          check("xfer_expected", exp_q.size() != 0, 1'b1);
          check("hsize", HSIZE, 3'b010);
          dp_data = '0;
          if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check("haddr", HADDR, x.addr);
            check("hwrite", HWRITE, x.wr);
            dp_data = x.data;
          end
          dp_active = 1;
          dp_write = HWRITE;
          dp_addr = HADDR;
          dp_err = (xfer_idx == err_at);
          xfer_idx++;
          wait_left = ws;
          wd_seen = 0;
        end
      end else begin
        if (aw_active) begin
          check("htrans_hold", HTRANS, 2'b10);
          aw_active = 0;
        end
        HREADY = 1'b1;
        HRESP = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int ntr, len, eat, found;
    bit e, fl;
    bit [31:0] src, dst;

    #3;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hsize", HSIZE, 3'b010);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * (i + 1);
      ref_mem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * (i + 1);
    end

    // Basic zero-wait copy, then the same copy with two waits on every phase.
    run_copy(32'h100, 32'h200, 4, 0, -1, 0, 0, 0);
    run_copy(32'h100, 32'h240, 4, 2, -1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("basic_copy_word", mem.exists(32'h200 + 32'(4 * i)) ? mem[32'h200 + 32'(4 * i)] : 32'h0,
            32'h1111_1111 * (i + 1));
      check("wait_copy_word", mem.exists(32'h240 + 32'(4 * i)) ? mem[32'h240 + 32'(4 * i)] : 32'h0,
            32'h1111_1111 * (i + 1));
    end

    // ERROR on the read of the second word: only the first word is written.
    run_copy(32'h100, 32'h280, 3, 0, 2, 0, 0, 0);
    check("err_first_word", mem.exists(32'h280) ? mem[32'h280] : 32'h0, 32'h1111_1111);
    check("err_no_second_write", mem.exists(32'h284), 1'b0);

    // Boundaries: empty request, address wrap, start while busy (low bits set).
    run_copy(32'h100, 32'h2A0, 0, 0, -1, 0, 0, 0);
    run_copy(32'hFFFF_FFFC, 32'h2C0, 2, 1, -1, 0, 0, 0);
    run_copy(32'h103, 32'h2D2, 3, 0, -1, 0, 0, 1);

    // Reset while the first write address phase is on the bus.
    wait_idle();
    @(negedge HCLK);
    ws = 0;
    err_at = -1;
    xfer_idx = 0;
    plan(32'h100, 32'h2E0, 3, 0, 0, -1, ntr, e);
    src_addr = 32'h100;
    dst_addr = 32'h2E0;
    len_words = LW'(3);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10 && HWRITE) found = 1;
    end
    check("reached_wr_addr", found, 1);
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_htrans", HTRANS, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_haddr", HADDR, 32'h0);
    check("midrst_hwrite", HWRITE, 1'b0);
    check("midrst_hwdata", HWDATA, 32'h0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    run_copy(32'h100, 32'h2E0, 3, 0, -1, 0, 0, 0);
    check("post_reset_copy", mem.exists(32'h2E8) ? mem[32'h2E8] : 32'h0, 32'h3333_3333);

`ifdef AHB_COPY_FILL_EN
    run_copy(32'h0, 32'h300, 3, 0, -1, 1, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 3; i++)
      check("fill_word", mem.exists(32'h300 + 32'(4 * i)) ? mem[32'h300 + 32'(4 * i)] : 32'h0,
            32'hDEAD_BEEF);
`endif

    // Randomized requests, possibly overlapping, with waits and errors.
    for (int t = 0; t < 24; t++) begin
      src = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
      dst = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
      len = $urandom_range(0, 6);
      eat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * len)) : -1;
`ifdef AHB_COPY_FILL_EN
      fl = ($urandom_range(0, 3) == 0);
`else
      fl = 1'b0;
`endif
      run_copy(src, dst, len, $urandom_range(0, 2), eat, fl, $urandom, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
